mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM encoding for the two-port memory arbiter.
package mem_arb_pkg;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Wide enough for MAX_BURST up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Port-side and memory-side bus of the two-port memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);

  logic              req0, req1;
  logic              lock0, lock1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              rvalid0, rvalid1;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with zero-cycle grant and bounded locked bursts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  burst_q, burst_d, burst_inc;
  logic [1:0]        rvalid_q, rvalid_d, rvalid_v;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              gnt0, gnt1, acc, sel, sel_we, sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= PORT1;
      burst_q      <= '0;
      rvalid_q     <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      rvalid_q     <= rvalid_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Grant, beat mux and next-state; a granted port always has its request high
  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    rvalid_d     = '0;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
            gnt0 = (last_owner_q == PORT1);
            gnt1 = (last_owner_q == PORT0);
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
        LOCK0:   gnt0 = bus.req0;
        LOCK1:   gnt1 = bus.req1;
        default: ;
      endcase
    end

    acc       = gnt0 | gnt1;
    sel       = gnt1 ? PORT1 : PORT0;
    sel_we    = (sel == PORT1) ? bus.we1    : bus.we0;
    sel_lock  = (sel == PORT1) ? bus.lock1  : bus.lock0;
    sel_addr  = (sel == PORT1) ? bus.addr1  : bus.addr0;
    sel_wdata = (sel == PORT1) ? bus.wdata1 : bus.wdata0;
    burst_inc = burst_q + CNT_W'(1);

    if (acc) begin
      last_owner_d = sel;
      if (!sel_we) rvalid_d = (sel == PORT1) ? 2'b10 : 2'b01;
      // The beat that reaches MAX_BURST releases ownership even with lock held
      if (sel_lock && (burst_inc < CNT_W'(MAX_BURST))) begin
        state_d = (sel == PORT1) ? LOCK1 : LOCK0;
        burst_d = burst_inc;
      end else begin
        state_d = IDLE;
        burst_d = '0;
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
      burst_d = '0;
    end
  end

  // Read data passes straight through on the valid cycle and is held afterwards
  always_comb begin
    rvalid_v = rvalid_q & {2{~reset}};
    rdata0_d = rvalid_v[0] ? bus.mem_rdata : rdata0_q;
    rdata1_d = rvalid_v[1] ? bus.mem_rdata : rdata1_q;
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_en    = acc;
  assign bus.mem_we    = acc & sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;
  assign bus.rvalid0   = rvalid_v[0];
  assign bus.rvalid1   = rvalid_v[1];
  assign bus.rdata0    = rdata0_d;
  assign bus.rdata1    = rdata1_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-scenario tasks plus a read-data monitor.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [DW-1:0] last0 = '0, last1 = '0;
  exp_t        q0[$], q1[$];

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hC8;
  endfunction

  // Memory model: read data appears the cycle after a read strobe, junk otherwise
  always @(posedge clk)
    bus.mem_rdata <= (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) ? rd_pat(bus.mem_addr) : 8'($urandom);

  // Scoreboard monitor: rvalid/rdata per port, and grant sanity
  always @(negedge clk) begin
    if (mon_en) begin
      logic ev0, ev1;
      ev0 = !reset && q0.size() > 0 && q0[0].due == cyc;
      ev1 = !reset && q1.size() > 0 && q1[0].due == cyc;
      checks++;
      if (bus.rvalid0 !== ev0) begin failures++; $display("FAIL mon_rvalid0 cyc=%0d got=%b exp=%b", cyc, bus.rvalid0, ev0); end
      checks++;
      if (bus.rvalid1 !== ev1) begin failures++; $display("FAIL mon_rvalid1 cyc=%0d got=%b exp=%b", cyc, bus.rvalid1, ev1); end
      if (ev0) begin last0 = q0[0].data; void'(q0.pop_front()); end
      if (ev1) begin last1 = q1[0].data; void'(q1.pop_front()); end
      checks++;
      if (bus.rdata0 !== last0) begin failures++; $display("FAIL mon_rdata0 cyc=%0d got=%h exp=%h", cyc, bus.rdata0, last0); end
      checks++;
      if (bus.rdata1 !== last1) begin failures++; $display("FAIL mon_rdata1 cyc=%0d got=%h exp=%h", cyc, bus.rdata1, last1); end
      checks++;
      if ((bus.gnt0 && bus.gnt1) || (bus.gnt0 && !bus.req0) || (bus.gnt1 && !bus.req1)) begin
        failures++; $display("FAIL mon_gnt cyc=%0d got=%b%b req=%b%b", cyc, bus.gnt1, bus.gnt0, bus.req1, bus.req0);
      end
      if (reset) begin last0 = '0; last1 = '0; end
    end
  end

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  // Enters and leaves at posedge+1
  task automatic apply_reset(input int n);
    reset = 1'b1;
    idle_inputs();
    q0.delete(); q1.delete();
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.req0 = 1; bus.req1 = 1;
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1} !== 6'b0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=000000",
        {bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1});
    end
    @(posedge clk); #1;
    reset = 1'b0; idle_inputs(); mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=00/00", bus.rdata0, bus.rdata1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'hFFFC;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin failures++; $display("FAIL rd_gnt got=%b%b exp=01", bus.gnt1, bus.gnt0); end
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'hFFFC) begin
      failures++; $display("FAIL rd_mem got en=%b we=%b addr=%h exp en=1 we=0 addr=fffc", bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    q0.push_back('{cyc + 1, 8'h34});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'h34) begin
      failures++; $display("FAIL rd_rvalid got v=%b d=%h exp v=1 d=34", bus.rvalid0, bus.rdata0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};
    apply_reset(1);
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 16'h0010; bus.addr1 = 16'h0021;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt0 !== (exp_g[i] == 0) || bus.gnt1 !== (exp_g[i] == 1)) begin
        failures++; $display("FAIL rr_gnt beat=%0d got=%b%b exp_port=%0d", i, bus.gnt1, bus.gnt0, exp_g[i]);
      end
      checks++;
      if (bus.mem_addr !== (exp_g[i] == 1 ? bus.addr1 : bus.addr0)) begin
        failures++; $display("FAIL rr_addr beat=%0d got=%h exp_port=%0d", i, bus.mem_addr, exp_g[i]);
      end
      if (exp_g[i] == 0) q0.push_back('{cyc + 1, rd_pat(16'h0010)});
      else               q1.push_back('{cyc + 1, rd_pat(16'h0021)});
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk); @(posedge clk); #1;
  endtask

  task automatic test_lock_burst();
    apply_reset(1);
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 16'h0030;
    bus.req1 = 1; bus.addr1 = 16'h0041;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt0 !== (i < 4) || bus.gnt1 !== (i == 4)) begin
        failures++; $display("FAIL burst_gnt beat=%0d got=%b%b exp=%b%b", i, bus.gnt1, bus.gnt0, i == 4, i < 4);
      end
      if (i < 4) q0.push_back('{cyc + 1, rd_pat(16'h0030)});
      else       q1.push_back('{cyc + 1, rd_pat(16'h0041)});
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk); @(posedge clk); #1;
  endtask

  task automatic test_write();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0200; bus.wdata1 = 8'hEA;
    @(negedge clk);
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=10", bus.gnt1, bus.gnt0); end
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0200 || bus.mem_wdata !== 8'hEA) begin
      failures++; $display("FAIL wr_mem got en=%b we=%b addr=%h wd=%h exp en=1 we=1 addr=0200 wd=ea",
        bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.rvalid1 !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0", bus.rvalid1); end
    @(posedge clk); #1;
  endtask

  task automatic test_lock_release();
    apply_reset(1);
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 16'h0050; bus.req1 = 1; bus.addr1 = 16'h0061;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin failures++; $display("FAIL rel_first got=%b%b exp=01", bus.gnt1, bus.gnt0); end
    q0.push_back('{cyc + 1, rd_pat(16'h0050)});
    @(posedge clk); #1;
    bus.lock0 = 0;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin failures++; $display("FAIL rel_locked got=%b%b exp=01", bus.gnt1, bus.gnt0); end
    q0.push_back('{cyc + 1, rd_pat(16'h0050)});
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin failures++; $display("FAIL rel_rr got=%b%b exp=10", bus.gnt1, bus.gnt0); end
    q1.push_back('{cyc + 1, rd_pat(16'h0061)});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk); @(posedge clk); #1;
  endtask

  task automatic test_lock_drop();
    apply_reset(1);
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 16'h0070; bus.req1 = 1; bus.addr1 = 16'h0081;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin failures++; $display("FAIL drop_first got=%b%b exp=01", bus.gnt1, bus.gnt0); end
    q0.push_back('{cyc + 1, rd_pat(16'h0070)});
    @(posedge clk); #1;
    bus.req0 = 0; bus.lock0 = 0;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL drop_idle got gnt=%b%b en=%b we=%b exp gnt=00 en=0 we=0", bus.gnt1, bus.gnt0, bus.mem_en, bus.mem_we);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.mem_addr !== 16'h0081) begin
      failures++; $display("FAIL drop_resume got gnt1=%b addr=%h exp gnt1=1 addr=0081", bus.gnt1, bus.mem_addr);
    end
    q1.push_back('{cyc + 1, rd_pat(16'h0081)});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset_after_read();
    bus.req0 = 1; bus.addr0 = 16'h00A5;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL rst_rd_gnt got=%b exp=1", bus.gnt0); end
    q0.push_back('{cyc + 1, rd_pat(16'h00A5)});
    @(posedge clk); #1;
    reset = 1'b1; idle_inputs(); q0.delete(); q1.delete();
    @(negedge clk);
    checks++;
    if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== rd_pat(16'h0070)) begin
      failures++; $display("FAIL rst_rd_during got v=%b d=%h exp v=0 d=%h", bus.rvalid0, bus.rdata0, rd_pat(16'h0070));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 8'h00) begin
      failures++; $display("FAIL rst_rd_after got v=%b d=%h exp v=0 d=00", bus.rvalid0, bus.rdata0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_burst();
    test_write();
    test_lock_release();
    test_lock_drop();
    test_reset_after_read();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
